uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 148 ++++++++++++++
 tb/tb_uart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver state encoding, the oversampling constants and the
// frame-format defaults so that uart_rx and the future uart_tx agree on
// them. No ports.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // 16x oversampling: the middle of the start bit is reached after 8 ticks
  // (s counts 0..7), after which every bit is one full BIT_TICKS period.
  localparam int START_MID   = 7;
  localparam int BIT_TICKS   = 16;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser for an asynchronous input.
// Both flops reset to 1 so an idle-high line does not look like a start
// edge on the way out of reset.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   d_i   - asynchronous input
//   q_o   - synchronised output (2 clk latency)
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver.
// Frame format: 1 start bit, DBIT data bits LSB first, no parity, stop time
// of SB_TICK oversampling ticks. Timing comes from an external 16x tick
// strobe so one baud generator can serve both receiver and transmitter.
// Ports:
//   clk          - system clock
//   reset        - synchronous, active-high reset
//   rx           - asynchronous serial input, idle high
//   s_tick       - one-clk strobe at 16x the baud rate
//   dout         - last received data word, held until the next frame
//   rx_done_tick - one-clk pulse when a frame completes
//   frame_err    - stop bit was sampled low on the last frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [4:0]    S_START_MID = 5'(START_MID);
  localparam logic [4:0]    S_BIT_LAST  = 5'(BIT_TICKS - 1);
  localparam logic [4:0]    S_STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  logic rxs;

  state_e          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rxs)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;

    unique case (state_q)
      // The start edge is taken on any clk so a frame that begins right
      // after the previous STOP->IDLE transition is not missed.
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          s_d     = '0;
        end
      end

      // Re-check the line at mid start bit; a high level here was a glitch.
      START: begin
        if (s_tick) begin
          if (s_q == S_START_MID) begin
            if (!rxs) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      // Sampling point stays at mid-bit because START ended at mid-bit.
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = DBIT'({rxs, b_q} >> 1);
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      // A low stop sample still delivers the word, flagged as a framing
      // error; a held-low line therefore reports repeated error frames.
      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~rxs;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
module tb_uart_rx;

  logic clk = 1'b0;
  always #50 clk = ~clk;  // 10 MHz

  logic       reset;
  logic       s_tick;
  logic       tick_en = 1'b1;
  logic       rx16;
  logic       rx32;
  logic [7:0] dout16, dout32;
  logic       done16, done32;
  logic       fe16, fe32;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx16),
    .s_tick       (s_tick),
    .dout         (dout16),
    .rx_done_tick (done16),
    .frame_err    (fe16)
  );

  uart_rx #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx32),
    .s_tick       (s_tick),
    .dout         (dout32),
    .rx_done_tick (done32),
    .frame_err    (fe32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       fe;
    int         start;
  } exp_t;

  exp_t q16[$];
  exp_t q32[$];

  // Tick strobe: one clk high every 5 clk, can be stalled.
  initial begin
    int div;
    div    = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        div    = (div == 4) ? 0 : div + 1;
        s_tick = (div == 0);
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  int tick_cnt = 0;
  always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

  // Done arrives on the tick 8 (mid start) + 16*8 (data) + SB_TICK after
  // the start edge, counting only delivered ticks.
  logic prev16 = 1'b0;
  logic prev32 = 1'b0;

  always @(negedge clk) begin
    if (done16) begin
      chk("w16", prev16, 1'b0);
      chk("pend16", q16.size() != 0, 1'b1);
      if (q16.size() != 0) begin
        chk("dout16", dout16, q16[0].d);
        chk("fe16", fe16, q16[0].fe);
        chk("lat16", tick_cnt - q16[0].start, 8 + 16 * 8 + 16);
        void'(q16.pop_front());
      end
    end
    prev16 <= done16;
  end

  always @(negedge clk) begin
    if (done32) begin
      chk("w32", prev32, 1'b0);
      chk("pend32", q32.size() != 0, 1'b1);
      if (q32.size() != 0) begin
        chk("dout32", dout32, q32[0].d);
        chk("fe32", fe32, q32[0].fe);
        chk("lat32", tick_cnt - q32[0].start, 8 + 16 * 8 + 32);
        void'(q32.pop_front());
      end
    end
    prev32 <= done32;
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (s_tick) k++;
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx32 = v;
    else     rx16 = v;
  endtask

  // Frames are tick-aligned: every line change happens on the negedge right
  // after a tick, so consecutive calls produce gap-free frames.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit stop_low,
                            input int stall_bit, input int rst_bit, input bit expect_out);
    int   sb;
    exp_t e;
    sb = sel ? 32 : 16;
    @(negedge clk);
    if (expect_out) begin
      e.d     = d;
      e.fe    = stop_low;
      e.start = tick_cnt;
      if (sel) q32.push_back(e);
      else     q16.push_back(e);
    end
    set_rx(sel, 1'b0);
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_rx(sel, d[i]);
      if (i == stall_bit || i == rst_bit) begin
        wait_ticks(8);
        @(negedge clk);
        if (i == stall_bit) begin
          tick_en = 1'b0;
          repeat (100) @(negedge clk);
          tick_en = 1'b1;
        end else begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          chk("rst_dout", dout16, 8'h00);
          chk("rst_fe", fe16, 1'b0);
        end
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    @(negedge clk);
    if (stop_low) begin
      // Low across the stop sample, released before the receiver's
      // mid-start re-check so no phantom frame follows.
      set_rx(sel, 1'b0);
      wait_ticks(10);
      @(negedge clk);
      set_rx(sel, 1'b1);
      wait_ticks(sb - 10);
    end else begin
      set_rx(sel, 1'b1);
      wait_ticks(sb);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q16.size() + q32.size()) != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", q16.size() + q32.size(), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    rx16  = 1'b1;
    rx32  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_dout16", dout16, 8'h00);
    chk("reset_fe16", fe16, 1'b0);
    chk("reset_done16", done16, 1'b0);
    chk("reset_dout32", dout32, 8'h00);
    chk("reset_done32", done32, 1'b0);

    // Single clean frame
    wait_ticks(1);
    send_frame(1'b0, 8'h55, 1'b0, -1, -1, 1'b1);
    drain();

    // Back-to-back frames
    wait_ticks(1);
    send_frame(1'b0, 8'hA3, 1'b0, -1, -1, 1'b1);
    send_frame(1'b0, 8'h0F, 1'b0, -1, -1, 1'b1);
    drain();

    // Short low glitch must be rejected
    wait_ticks(1);
    @(negedge clk);
    rx16 = 1'b0;
    repeat (15) @(negedge clk);
    rx16 = 1'b1;
    wait_ticks(40);
    chk("glitch_dout", dout16, 8'h0F);
    chk("glitch_fe", fe16, 1'b0);

    // Framing error, then a clean frame clears the flag
    send_frame(1'b0, 8'hC4, 1'b1, -1, -1, 1'b1);
    send_frame(1'b0, 8'h12, 1'b0, -1, -1, 1'b1);
    drain();

    // Reset during data bit 4 aborts the frame
    wait_ticks(1);
    send_frame(1'b0, 8'hFF, 1'b0, -1, 4, 1'b0);
    send_frame(1'b0, 8'h81, 1'b0, -1, -1, 1'b1);
    drain();
    chk("post_rst_dout", dout16, 8'h81);

    // Two stop bits with a tick stall in the middle of the data
    wait_ticks(1);
    send_frame(1'b1, 8'h7E, 1'b0, 3, -1, 1'b1);
    drain();
    chk("sb32_fe", fe32, 1'b0);

    wait_ticks(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
